hci_core_target_mem: RTL and testbench
======================================

Name: hci_core_target_mem

Overview:
- Synthesizable HCI core-protocol target (responder end): word-addressed flop-based memory behind a req/gnt request channel and an r_valid/r_ready response channel.
- Used as a TCDM bank model and scratchpad behind HCI interconnect leaves.
- Each granted request (load or store) yields exactly one in-order response.
- A response FIFO absorbs r_ready backpressure; gnt is throttled by free FIFO space.

Parameters:
- DW, 32, data width.
- AW, 32, byte-address width.
- BW, 8, byte width in bits; DW must be a multiple of BW.
- UW, 1, user width.
- IW, 1, ID width.
- NUM_WORDS, 1024, memory depth in DW-bit words; must be at least 1.
- RSP_DEPTH, 2, response FIFO depth; must be at least 1.
- STALL_SEED, 16'hACE1, nonzero LFSR seed (used only with the optional feature).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- req_i  in  1  request valid.
- gnt_o  out  1  request grant.
- add_i  in  AW  byte address.
- wen_i  in  1  1 = load, 0 = store.
- data_i  in  DW  store data.
- be_i  in  DW/BW  byte enables.
- user_i  in  UW  request user.
- id_i  in  IW  request ID.
- r_valid_o  out  1  response valid.
- r_ready_i  in  1  response ready.
- r_data_o  out  DW  load data; 0 for stores and errors.
- r_user_o  out  UW  echoed user.
- r_id_o  out  IW  echoed ID.
- r_opc_o  out  1  0 = OK, 1 = error (out of range).

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk_i, rst_i).
- Reset values: gnt_o=0 while rst_i=1. FIFO is emptied: r_valid_o=0, r_data_o/r_user_o/r_id_o/r_opc_o=0. Memory contents are not reset.
- Word index: idx = add_i[AW-1:$clog2(DW/BW)]. The low byte-offset bits are ignored.
- Range check: out of range when idx >= NUM_WORDS.
- Fill level: cnt, width $clog2(RSP_DEPTH+1).
- Pop: pop = r_valid_o & r_ready_i.
- Grant: gnt_o = req_i & (cnt < RSP_DEPTH | pop). gnt_o may depend combinationally on req_i and r_ready_i; there is no combinational path from any response output to a request input.
- Accept occurs when req_i & gnt_o is high at a rising edge:
  - Store in range: mem[idx] is updated per byte where be_i=1; bytes with be=0 keep their value.
  - Load in range: mem[idx] is read with the pre-edge contents; bytes are not masked by be.
  - Any out-of-range access: no memory write; response carries r_data=0, r_opc=1.
  - Every accept pushes {r_data, user_i, id_i, opc} into the FIFO in the same edge.
- Latency: a request granted in cycle N produces r_valid_o in cycle N+1 if the FIFO was empty or was popped in N. Otherwise the response is queued behind older ones, in order.
- Read-after-write: a load granted in the cycle after a store to the same word returns the new data.
- r_valid_o = (cnt != 0). The FIFO head drives r_* outputs.
- RSP stability: while r_valid_o=1 and r_ready_i=0, r_valid_o and all r_* outputs hold (no retire, no change).
- Full FIFO: cnt==RSP_DEPTH and no pop gives gnt_o=0. When full with a pop, push and pop happen in the same edge and cnt is unchanged.
- Empty FIFO: push with no pop gives cnt+1. Pop is impossible when empty.
- Request side: the block itself requires no stability from the initiator, but it samples payload only at the accept edge.
- Reset mid-operation: queued responses are dropped. A request accepted in the reset cycle is not performed, because gnt_o=0 during reset.

Optional Feature:
- Macro: HCI_TARGET_STALL_EN.
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11) is seeded with STALL_SEED on reset and advances every cycle. gnt_o is additionally ANDed with ~(lfsr[1:0]==2'b00), giving about 25% random grant stalls. This exercises initiator RQ stability and no-retire.
- Undefined: no LFSR is present, and gnt_o follows only the FIFO rule above.

Decomposition:
- hci_package: add opc constants HCI_OPC_OK=1'b0 and HCI_OPC_ERR=1'b1.
- The response entry typedef is local and parameterised by DW/UW/IW.
- Sub-module hci_target_rsp_fifo: generic ordered FIFO with push, pop, cnt, full and empty, plus synchronous reset. It is reused by other HCI targets.
- The top level holds address decode, byte-enable write and the grant rule.

Test Plan:
- Basic write/read: store add=0x10, data=0xDEADBEEF, be=4'hF, then load add=0x10 with r_ready=1. Expect r_valid one cycle after each grant. The load returns 0xDEADBEEF with opc=0; the store response returns r_data=0.
- Partial store: store 0x11223344 with be=4'b0101 over 0xDEADBEEF at the same word. A subsequent load returns 0xDE22BE44.
- Out of range: load at word NUM_WORDS (add=4*NUM_WORDS). Expect r_opc=1 and r_data=0. A store there leaves word 0 unchanged.
- Backpressure: hold r_ready=0 with RSP_DEPTH=2 and issue 3 back-to-back loads with ids 0,1,2. The first two are granted and gnt_o=0 on the third. r_* holds stable. Raising r_ready returns ids 0,1,2 in order, and the third is granted in the same cycle as the first pop.
- Reset mid-operation: with 2 responses queued, assert rst_i for 1 cycle. Expect r_valid_o=0 and gnt_o=0 during reset. Memory data written earlier is still readable afterwards.
- With HCI_TARGET_STALL_EN: 1000 random requests under a random r_ready. Expect no lost or reordered responses, RSP stability holds, and the gnt stall rate is roughly 25% ±5%.

Source files
------------

// File: rtl/hci_package.sv
// Shared HCI definitions: response opcodes and the grant-stall LFSR step.
package hci_package;

  localparam logic HCI_OPC_OK  = 1'b0;
  localparam logic HCI_OPC_ERR = 1'b1;

  // 16-bit Fibonacci LFSR, taps 16,14,13,11, shifting towards the MSB
  function automatic logic [15:0] hci_lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/hci_target_rsp_fifo.sv
// Generic in-order FIFO with synchronous reset; head reads as zero when empty.
module hci_target_rsp_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH+1)-1:0] cnt_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] store_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign cnt_o   = cnt_q;
  assign do_pop  = pop_i & ~empty_o;
  // A push into a full FIFO is legal only when the head retires in the same edge
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = empty_o ? '0 : store_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wrap_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = wrap_inc(rd_ptr_q);
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) store_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/hci_core_target_mem.sv
// HCI core-protocol target: word-addressed flop memory with an in-order response FIFO.
// Optional random grant stalls are built in when HCI_TARGET_STALL_EN is defined.
module hci_core_target_mem
  import hci_package::*;
#(
  parameter int unsigned DW         = 32,
  parameter int unsigned AW         = 32,
  parameter int unsigned BW         = 8,
  parameter int unsigned UW         = 1,
  parameter int unsigned IW         = 1,
  parameter int unsigned NUM_WORDS  = 1024,
  parameter int unsigned RSP_DEPTH  = 2,
  parameter logic [15:0] STALL_SEED = 16'hACE1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_i,
  output logic             gnt_o,
  input  logic [AW-1:0]    add_i,
  input  logic             wen_i,
  input  logic [DW-1:0]    data_i,
  input  logic [DW/BW-1:0] be_i,
  input  logic [UW-1:0]    user_i,
  input  logic [IW-1:0]    id_i,
  output logic             r_valid_o,
  input  logic             r_ready_i,
  output logic [DW-1:0]    r_data_o,
  output logic [UW-1:0]    r_user_o,
  output logic [IW-1:0]    r_id_o,
  output logic             r_opc_o
);

  localparam int unsigned NB   = DW / BW;
  localparam int unsigned OFFW = $clog2(NB);
  localparam int unsigned MW   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int unsigned RW   = (AW > 32) ? AW + 1 : 33;
  localparam int unsigned FCW  = $clog2(RSP_DEPTH + 1);

  typedef struct packed {
    logic [DW-1:0] data;
    logic [UW-1:0] user;
    logic [IW-1:0] id;
    logic          opc;
  } rsp_t;

  logic [DW-1:0] mem_q [NUM_WORDS];

  logic [AW-1:0]  idx;
  logic [MW-1:0]  mem_addr;
  logic           in_range;
  logic [DW-1:0]  rdata, wdata;
  logic           accept, do_write, pop, stall_ok;
  rsp_t           push_entry, head;
  logic [FCW-1:0] rsp_cnt;
  logic           rsp_empty, rsp_full_unused;

  assign idx      = add_i >> OFFW;
  assign mem_addr = idx[MW-1:0];
  // Widened compare so NUM_WORDS == 2**index_width does not wrap to zero
  assign in_range = RW'(idx) < RW'(NUM_WORDS);
  assign rdata    = mem_q[mem_addr];

  assign pop      = r_valid_o & r_ready_i;
  assign gnt_o    = req_i & ~rst_i & ((rsp_cnt < FCW'(RSP_DEPTH)) | pop) & stall_ok;
  assign accept   = req_i & gnt_o;
  assign do_write = accept & ~wen_i & in_range;

  always_comb begin
    wdata = rdata;
    for (int b = 0; b < NB; b++) begin
      if (be_i[b]) wdata[b*BW +: BW] = data_i[b*BW +: BW];
    end
  end

  always_comb begin
    push_entry.data = (wen_i & in_range) ? rdata : '0;
    push_entry.user = user_i;
    push_entry.id   = id_i;
    push_entry.opc  = in_range ? HCI_OPC_OK : HCI_OPC_ERR;
  end

  always_ff @(posedge clk_i) begin
    if (do_write) mem_q[mem_addr] <= wdata;
  end

`ifdef HCI_TARGET_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb lfsr_d = hci_lfsr_next(lfsr_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr_q <= STALL_SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign stall_ok = (lfsr_q[1:0] != 2'b00);
`else
  logic [15:0] stall_seed_unused;
  assign stall_seed_unused = STALL_SEED;
  assign stall_ok          = 1'b1;
`endif

  hci_target_rsp_fifo #(
    .WIDTH ($bits(rsp_t)),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (accept),
    .data_i  (push_entry),
    .pop_i   (pop),
    .data_o  (head),
    .cnt_o   (rsp_cnt),
    .full_o  (rsp_full_unused),
    .empty_o (rsp_empty)
  );

  assign r_valid_o = ~rsp_empty;
  assign r_data_o  = head.data;
  assign r_user_o  = head.user;
  assign r_id_o    = head.id;
  assign r_opc_o   = head.opc;

endmodule

// File: tb/tb_hci_core_target_mem.sv
// Bench for hci_core_target_mem: queue/array reference model plus directed and random traffic.
module tb_hci_core_target_mem;

  localparam int NW    = 1024;
  localparam int DEPTH = 2;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_i = 1'b0;
  logic        gnt_o;
  logic [31:0] add_i = '0;
  logic        wen_i = 1'b1;
  logic [31:0] data_i = '0;
  logic [3:0]  be_i = '0;
  logic [0:0]  user_i = '0;
  logic [1:0]  id_i = '0;
  logic        r_valid_o;
  logic        r_ready_i = 1'b1;
  logic [31:0] r_data_o;
  logic [0:0]  r_user_o;
  logic [1:0]  r_id_o;
  logic        r_opc_o;

  hci_core_target_mem #(
    .DW(32), .AW(32), .BW(8), .UW(1), .IW(2),
    .NUM_WORDS(NW), .RSP_DEPTH(DEPTH), .STALL_SEED(16'hACE1)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o),
    .add_i(add_i), .wen_i(wen_i), .data_i(data_i), .be_i(be_i),
    .user_i(user_i), .id_i(id_i), .r_valid_o(r_valid_o), .r_ready_i(r_ready_i),
    .r_data_o(r_data_o), .r_user_o(r_user_o), .r_id_o(r_id_o), .r_opc_o(r_opc_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] data;
    logic [31:0] mask;
    logic [0:0]  user;
    logic [1:0]  id;
    logic        opc;
  } ent_t;

  ent_t        q[$];
  logic [31:0] mm [NW];
  logic [3:0]  mk [NW];
  logic [15:0] ml = 16'hACE1;
  int          elig_n = 0;
  int          stall_n = 0;

  initial for (int i = 0; i < NW; i++) mk[i] = 4'h0;

  function automatic logic [31:0] expand(input logic [3:0] m);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[b*8 +: 8] = {8{m[b]}};
    return r;
  endfunction

  function automatic bit space_ok();
    return (q.size() < DEPTH) || (q.size() > 0 && r_ready_i);
  endfunction

  function automatic bit stall_free();
`ifdef HCI_TARGET_STALL_EN
    return ml[1:0] != 2'b00;
`else
    return 1'b1;
`endif
  endfunction

  function automatic bit m_gnt();
    return !rst_i && req_i && space_ok() && stall_free();
  endfunction

  always @(posedge clk_i) begin
    ent_t e;
    bit acc, pp;
    longint unsigned wa;
    if (rst_i) begin
      q.delete();
      ml = 16'hACE1;
    end else begin
      acc = m_gnt();
      pp  = q.size() > 0 && r_ready_i;
      if (req_i && space_ok()) begin
        elig_n++;
        if (!stall_free()) stall_n++;
      end
      if (acc) begin
        wa     = longint'(add_i) >> 2;
        e.user = user_i;
        e.id   = id_i;
        e.data = '0;
        e.mask = '1;
        e.opc  = (wa >= NW);
        if (wa < NW) begin
          if (wen_i) begin
            e.data = mm[wa];
            e.mask = expand(mk[wa]);
          end else begin
            for (int b = 0; b < 4; b++)
              if (be_i[b]) begin
                mm[wa][b*8 +: 8] = data_i[b*8 +: 8];
                mk[wa][b] = 1'b1;
              end
          end
        end
      end
      if (pp) void'(q.pop_front());
      if (acc) q.push_back(e);
      ml = {ml[14:0], ml[15] ^ ml[13] ^ ml[12] ^ ml[10]};
    end
  end

  always @(negedge clk_i) begin
    chk("gnt", gnt_o, m_gnt());
    chk("r_valid", r_valid_o, q.size() > 0);
    if (q.size() > 0) begin
      chk("r_data", r_data_o & q[0].mask, q[0].data & q[0].mask);
      chk("r_id", r_id_o, q[0].id);
      chk("r_user", r_user_o, q[0].user);
      chk("r_opc", r_opc_o, q[0].opc);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit rq, input bit wn, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic [1:0] id);
    @(posedge clk_i); #1;
    req_i = rq; wen_i = wn; add_i = a; data_i = d; be_i = be; id_i = id;
  endtask

  // One transaction with r_ready high and an empty FIFO; returns the response.
  task automatic xfer(input bit wn, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be, input logic [1:0] id,
                      output logic [31:0] rd, output logic opc);
    int n = 0;
    drive(1'b1, wn, a, d, be, id);
    @(negedge clk_i);
    while (!gnt_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (!gnt_o) chk("gnt_timeout", 0, 1);
    @(posedge clk_i); #1;
    req_i = 1'b0;
    @(negedge clk_i);
    chk("latency_one", r_valid_o, 1);
    chk("echo_id", r_id_o, id);
    rd  = r_data_o;
    opc = r_opc_o;
  endtask

  initial begin
    logic [31:0] rd;
    logic        opc;
    int          pct;

    req_i = 1'b1;
    repeat (2) @(negedge clk_i);
    chk("rst_gnt", gnt_o, 0);
    chk("rst_valid", r_valid_o, 0);
    chk("rst_data", r_data_o, 0);
    chk("rst_opc", r_opc_o, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    req_i = 1'b0;

    xfer(1'b0, 32'h10, 32'hDEADBEEF, 4'hF, 2'd1, rd, opc);
    chk("store_rdata", rd, 0);
    chk("store_opc", opc, 0);
    xfer(1'b1, 32'h10, 32'h0, 4'h0, 2'd2, rd, opc);
    chk("load_full", rd, 32'hDEADBEEF);
    chk("load_opc", opc, 0);

    xfer(1'b0, 32'h10, 32'h11223344, 4'b0101, 2'd3, rd, opc);
    xfer(1'b1, 32'h13, 32'h0, 4'h0, 2'd0, rd, opc);
    chk("partial_store", rd, 32'hDE22BE44);

    xfer(1'b0, 32'h0, 32'h12345678, 4'hF, 2'd1, rd, opc);
    xfer(1'b1, 32'h1000, 32'h0, 4'hF, 2'd2, rd, opc);
    chk("oob_load_opc", opc, 1);
    chk("oob_load_data", rd, 0);
    xfer(1'b0, 32'h1000, 32'hFFFFFFFF, 4'hF, 2'd3, rd, opc);
    chk("oob_store_opc", opc, 1);
    xfer(1'b1, 32'h0, 32'h0, 4'h0, 2'd0, rd, opc);
    chk("oob_no_alias", rd, 32'h12345678);

`ifndef HCI_TARGET_STALL_EN
    @(posedge clk_i); #1;
    r_ready_i = 1'b0;
    drive(1'b1, 1'b1, 32'h10, 32'h0, 4'hF, 2'd0);
    @(negedge clk_i); chk("bp_gnt0", gnt_o, 1);
    drive(1'b1, 1'b1, 32'h10, 32'h0, 4'hF, 2'd1);
    @(negedge clk_i); chk("bp_gnt1", gnt_o, 1);
    drive(1'b1, 1'b1, 32'h10, 32'h0, 4'hF, 2'd2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("bp_gnt_full", gnt_o, 0);
      chk("bp_hold_id", r_id_o, 0);
      chk("bp_hold_data", r_data_o, 32'hDE22BE44);
    end
    @(posedge clk_i); #1;
    r_ready_i = 1'b1;
    @(negedge clk_i);
    chk("bp_gnt_on_pop", gnt_o, 1);
    chk("bp_order0", r_id_o, 0);
    @(posedge clk_i); #1;
    req_i = 1'b0;
    @(negedge clk_i); chk("bp_order1", r_id_o, 1);
    @(negedge clk_i); chk("bp_order2", r_id_o, 2);
    @(negedge clk_i); chk("bp_drained", r_valid_o, 0);
`endif

    @(posedge clk_i); #1;
    r_ready_i = 1'b0;
    drive(1'b1, 1'b1, 32'h10, 32'h0, 4'hF, 2'd1);
    drive(1'b1, 1'b1, 32'h0, 32'h0, 4'hF, 2'd2);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("midrst_gnt", gnt_o, 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    req_i = 1'b0;
    r_ready_i = 1'b1;
    @(negedge clk_i);
    chk("midrst_valid", r_valid_o, 0);
    chk("midrst_data", r_data_o, 0);
    xfer(1'b1, 32'h10, 32'h0, 4'h0, 2'd3, rd, opc);
    chk("mem_survives_rst", rd, 32'hDE22BE44);

    for (int i = 0; i < 1000; i++) begin
      @(posedge clk_i); #1;
      req_i     = ($urandom_range(0, 3) != 0);
      wen_i     = $urandom_range(0, 1);
      add_i     = ($urandom_range(0, 7) == 0) ? 32'h1000 + 32'($urandom_range(0, 15))
                                              : 32'($urandom_range(0, 31));
      data_i    = $urandom;
      be_i      = 4'($urandom_range(0, 15));
      id_i      = 2'($urandom_range(0, 3));
      user_i    = 1'($urandom_range(0, 1));
      r_ready_i = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk_i); #1;
    req_i = 1'b0;
    r_ready_i = 1'b1;
    repeat (4) @(negedge clk_i);
    chk("final_drain", r_valid_o, 0);

`ifdef HCI_TARGET_STALL_EN
    pct = (elig_n > 0) ? (stall_n * 100) / elig_n : 0;
    chk("stall_rate_20_30", (pct >= 20 && pct <= 30), 1);
`else
    pct = stall_n;
    chk("no_stalls", pct, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule
